// File: rtl/iq_free_list_pkg.sv
// rtl/iq_free_list_pkg.sv - shared types, sizes and helpers for the IQ free list
// Purpose: sizing constants, the {valid,id} entry packet and a popcount helper.
// Ports: none (package).
package iq_free_list_pkg;

  localparam int SIZE_IQ          = 32;
  localparam int NUM_PARTS        = 4;
  localparam int DISPATCH_WIDTH   = 4;
  localparam int ISSUE_WIDTH      = 4;
  localparam int SIZE_IQ_LOG      = $clog2(SIZE_IQ);
  localparam int NUM_PARTS_IQ_LOG = $clog2(NUM_PARTS);
  localparam int PART_SIZE        = SIZE_IQ / NUM_PARTS;
  localparam int DISP_CNT_W       = $clog2(DISPATCH_WIDTH + 1);
  localparam int FREE_CNT_W       = $clog2(ISSUE_WIDTH + 1);

  typedef logic [SIZE_IQ_LOG-1:0] iq_id_t;
  typedef logic [SIZE_IQ_LOG:0]   iq_cnt_t;

  typedef struct packed {
    logic   valid;
    iq_id_t id;
  } iq_entry_pkt;

  function automatic iq_cnt_t popcount(input logic [SIZE_IQ-1:0] v);
    iq_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < SIZE_IQ; i++) begin
      cnt = cnt + iq_cnt_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/iq_free_list_if.sv
// rtl/iq_free_list_if.sv - dispatch/issue-side bundle of the IQ free list
// Purpose: groups the flush, dispatch request, freed-entry and allocation signals.
// Ports: master = dispatch/issue side (drives requests, frees, flush),
//        slave  = free list (drives allocated entries, stall, fire, count).
interface iq_free_list_if;
  import iq_free_list_pkg::*;

  logic                                  flush;
  logic        [NUM_PARTS-1:0]           part_active;
  logic                                  dispatch_req;
  logic        [DISPATCH_WIDTH-1:0]      lane_active;
  iq_entry_pkt [ISSUE_WIDTH-1:0]         freed_entry;
  iq_entry_pkt [DISPATCH_WIDTH-1:0]      free_entry;
  logic                                  iq_stall;
  logic                                  dispatch_fire;
  iq_cnt_t                               free_count;

  modport master (
    output flush, part_active, dispatch_req, lane_active, freed_entry,
    input  free_entry, iq_stall, dispatch_fire, free_count
  );

  modport slave (
    input  flush, part_active, dispatch_req, lane_active, freed_entry,
    output free_entry, iq_stall, dispatch_fire, free_count
  );

endinterface

// File: rtl/iq_free_list_lane_prefix.sv
// rtl/iq_free_list_lane_prefix.sv - exclusive prefix count of a lane valid vector
// Purpose: rank[i] = number of set bits below lane i; total = number of set bits.
// Ports: valid (in, WIDTH), rank (out, WIDTH x CNT_W), total (out, CNT_W).
module iq_lane_prefix #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            valid,
  output logic [WIDTH-1:0][CNT_W-1:0] rank,
  output logic [CNT_W-1:0]            total
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rank[i] = acc;
      acc     = acc + CNT_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/iq_free_list.sv
// rtl/iq_free_list.sv - circular free list of issue-queue entry IDs
// Purpose: hands one unique free IQ entry per active dispatch lane each cycle and
//          takes back entries released by issue; partition-aware refill on flush.
// Ports: clk, rst_n (async active-low), bus (iq_free_list_if.slave).
module iq_free_list
  import iq_free_list_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  iq_free_list_if.slave bus
);

  iq_id_t  id_buf [SIZE_IQ];
  iq_id_t  refill_buf [SIZE_IQ];
  iq_id_t  head;
  iq_id_t  tail;
  iq_cnt_t count;
  iq_cnt_t flush_count;
  iq_cnt_t refill_slot;
  logic [NUM_PARTS-1:0] part_mask;

  logic [DISPATCH_WIDTH-1:0][DISP_CNT_W-1:0] req_rank;
  logic [DISP_CNT_W-1:0]                     n_req;
  logic [ISSUE_WIDTH-1:0]                    free_valid;
  logic [ISSUE_WIDTH-1:0][FREE_CNT_W-1:0]    free_rank;
  logic [FREE_CNT_W-1:0]                     n_free;
  iq_cnt_t                                   n_req_ext;
  iq_cnt_t                                   n_free_ext;

  logic        stall;
  logic        grant;
  logic        fire;
  iq_entry_pkt [DISPATCH_WIDTH-1:0] alloc;

  always_comb begin
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      free_valid[l] = bus.freed_entry[l].valid;
    end
  end

  iq_lane_prefix #(.WIDTH(DISPATCH_WIDTH), .CNT_W(DISP_CNT_W)) u_req_prefix (
    .valid (bus.lane_active),
    .rank  (req_rank),
    .total (n_req)
  );

  iq_lane_prefix #(.WIDTH(ISSUE_WIDTH), .CNT_W(FREE_CNT_W)) u_free_prefix (
    .valid (free_valid),
    .rank  (free_rank),
    .total (n_free)
  );

  assign n_req_ext  = iq_cnt_t'(n_req);
  assign n_free_ext = iq_cnt_t'(n_free);

  // Stall looks only at the registered count: same-cycle frees are not bypassed.
  assign stall = bus.dispatch_req & (count < n_req_ext);
  assign grant = bus.dispatch_req & ~stall & ~bus.flush;
  assign fire  = grant;

  // Lane compaction: the k-th active lane reads the k-th ID after head.
  always_comb begin
    alloc = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      alloc[l].valid = bus.lane_active[l] & grant;
      if (alloc[l].valid) begin
        alloc[l].id = id_buf[head + SIZE_IQ_LOG'(req_rank[l])];
      end
    end
  end

  assign bus.free_entry    = alloc;
  assign bus.iq_stall      = stall;
  assign bus.dispatch_fire = fire;
  assign bus.free_count    = count;

  // Flush image: IDs of active partitions packed from slot 0 in ascending order.
  always_comb begin
    for (int i = 0; i < SIZE_IQ; i++) begin
      refill_buf[i] = SIZE_IQ_LOG'(i);
    end
    refill_slot = '0;
    for (int p = 0; p < NUM_PARTS; p++) begin
      if (bus.part_active[p]) begin
        for (int j = 0; j < PART_SIZE; j++) begin
          refill_buf[refill_slot[SIZE_IQ_LOG-1:0]] = SIZE_IQ_LOG'(p * PART_SIZE + j);
          refill_slot = refill_slot + 1'b1;
        end
      end
    end
  end

  assign flush_count = iq_cnt_t'(popcount(SIZE_IQ'(bus.part_active)) * PART_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE_IQ; i++) begin
        id_buf[i] <= SIZE_IQ_LOG'(i);
      end
      head      <= '0;
      tail      <= '0;
      count     <= iq_cnt_t'(SIZE_IQ);
      part_mask <= '1;
    end else if (bus.flush) begin
      for (int i = 0; i < SIZE_IQ; i++) begin
        id_buf[i] <= refill_buf[i];
      end
      head      <= '0;
      tail      <= flush_count[SIZE_IQ_LOG-1:0];
      count     <= flush_count;
      part_mask <= bus.part_active;
    end else begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (free_valid[l]) begin
          id_buf[tail + SIZE_IQ_LOG'(free_rank[l])] <= bus.freed_entry[l].id;
        end
      end
      if (fire) begin
        head <= head + SIZE_IQ_LOG'(n_req);
      end
      tail  <= tail + SIZE_IQ_LOG'(n_free);
      count <= count - (fire ? n_req_ext : '0) + n_free_ext;
    end
  end

  // Usage checks; the list does not try to recover from any of these.
  always @(posedge clk) begin
    if (rst_n && !bus.flush) begin
      assert ((count + n_free_ext) <= iq_cnt_t'(SIZE_IQ));
      for (int a = 0; a < ISSUE_WIDTH; a++) begin
        if (free_valid[a]) begin
          assert (part_mask[bus.freed_entry[a].id[SIZE_IQ_LOG-1 -: NUM_PARTS_IQ_LOG]]);
          for (int b = a + 1; b < ISSUE_WIDTH; b++) begin
            if (free_valid[b]) begin
              assert (bus.freed_entry[a].id != bus.freed_entry[b].id);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_free_list.sv
// tb/tb_iq_free_list.sv - self-checking bench for iq_free_list
module tb_iq_free_list;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  // Reference: queue of free IDs, front = next to hand out.
  int   fl [$];

  iq_free_list_if bus ();

  iq_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    fl = {};
    for (int i = 0; i < 32; i++) fl.push_back(i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (bus.flush) begin
      fl = {};
      for (int p = 0; p < 4; p++)
        if (bus.part_active[p])
          for (int j = 0; j < 8; j++) fl.push_back(p * 8 + j);
    end else begin
      int n;
      n = $countones(bus.lane_active);
      if (bus.dispatch_req && fl.size() >= n)
        repeat (n) void'(fl.pop_front());
      for (int l = 0; l < 4; l++)
        if (bus.freed_entry[l].valid) fl.push_back(int'(bus.freed_entry[l].id));
    end
  end

  // Per-cycle comparison against the queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      int  n, k;
      bit  exp_stall, exp_grant, exp_v;
      n         = $countones(bus.lane_active);
      exp_stall = bus.dispatch_req && (fl.size() < n);
      exp_grant = bus.dispatch_req && !exp_stall && !bus.flush;
      check("free_count", 32'(bus.free_count), fl.size());
      check("iq_stall", 32'(bus.iq_stall), 32'(exp_stall));
      check("dispatch_fire", 32'(bus.dispatch_fire), 32'(exp_grant));
      k = 0;
      for (int l = 0; l < 4; l++) begin
        exp_v = bus.lane_active[l] && exp_grant;
        check($sformatf("lane%0d_valid", l), 32'(bus.free_entry[l].valid), 32'(exp_v));
        if (exp_v)
          check($sformatf("lane%0d_id", l), 32'(bus.free_entry[l].id), fl[k]);
        else if (!bus.lane_active[l])
          check($sformatf("lane%0d_id_idle", l), 32'(bus.free_entry[l].id), 0);
        if (bus.lane_active[l]) k++;
      end
    end
  end

  function automatic logic [19:0] ids(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic set(input logic req, input logic [3:0] lanes, input logic [3:0] fv = 4'b0,
                     input logic [19:0] fid = 20'd0, input logic flush = 1'b0,
                     input logic [3:0] pm = 4'hf);
    bus.dispatch_req = req;
    bus.lane_active  = lanes;
    bus.flush        = flush;
    bus.part_active  = pm;
    for (int l = 0; l < 4; l++) begin
      bus.freed_entry[l].valid = fv[l];
      bus.freed_entry[l].id    = fid[l*5 +: 5];
    end
  endtask

  task automatic cyc(input logic req, input logic [3:0] lanes, input logic [3:0] fv = 4'b0,
                     input logic [19:0] fid = 20'd0, input logic flush = 1'b0,
                     input logic [3:0] pm = 4'hf);
    @(posedge clk);
    #1;
    set(req, lanes, fv, fid, flush, pm);
    #3;
  endtask

  task automatic expect_ids(input string tag, input int a, input int b, input int c, input int d);
    int e [4];
    e = '{a, b, c, d};
    for (int l = 0; l < 4; l++) begin
      check($sformatf("%s_v%0d", tag, l), 32'(bus.free_entry[l].valid), 1);
      check($sformatf("%s_id%0d", tag, l), 32'(bus.free_entry[l].id), e[l]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set(1'b0, 4'b0000);
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_free_count", 32'(bus.free_count), 32);
    check("rst_stall", 32'(bus.iq_stall), 0);
    check("rst_fire", 32'(bus.dispatch_fire), 0);
    for (int l = 0; l < 4; l++) check($sformatf("rst_v%0d", l), 32'(bus.free_entry[l].valid), 0);

    // First bundle in the first cycle after reset release.
    rst_n = 1'b1;
    set(1'b1, 4'b1111);
    #3;
    expect_ids("first", 0, 1, 2, 3);

    // Sparse lanes 0 and 2.
    cyc(1'b1, 4'b0101);
    check("sparse_count", 32'(bus.free_count), 28);
    check("sparse_id0", 32'(bus.free_entry[0].id), 4);
    check("sparse_id2", 32'(bus.free_entry[2].id), 5);
    check("sparse_v1", 32'(bus.free_entry[1].valid), 0);
    check("sparse_v3", 32'(bus.free_entry[3].valid), 0);

    // Drain down to two free entries.
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'b1111);

    // Three-lane request with only two free: stall even though ID 5 is freed now.
    cyc(1'b1, 4'b0111, 4'b0001, ids(5, 0, 0, 0));
    check("nobypass_count", 32'(bus.free_count), 2);
    check("nobypass_stall", 32'(bus.iq_stall), 1);
    check("nobypass_v0", 32'(bus.free_entry[0].valid), 0);
    cyc(1'b1, 4'b0111);
    check("retry_count", 32'(bus.free_count), 3);
    check("retry_fire", 32'(bus.dispatch_fire), 1);
    check("retry_id0", 32'(bus.free_entry[0].id), 30);
    check("retry_id1", 32'(bus.free_entry[1].id), 31);
    check("retry_id2", 32'(bus.free_entry[2].id), 5);

    // Zero-lane bundle still fires; empty list stalls while frees go in.
    cyc(1'b1, 4'b0000);
    check("zero_fire", 32'(bus.dispatch_fire), 1);
    cyc(1'b1, 4'b0001, 4'b1010, ids(0, 6, 0, 7));
    check("empty_stall", 32'(bus.iq_stall), 1);
    cyc(1'b0, 4'b0000);
    check("frees_only_count", 32'(bus.free_count), 2);

    // Full refill, then walk head to 30 and wrap.
    cyc(1'b0, 4'b0000, 4'b0000, 20'd0, 1'b1, 4'b1111);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'b1111);
    cyc(1'b1, 4'b0011);
    cyc(1'b0, 4'b0000, 4'b0011, ids(0, 1, 0, 0));
    cyc(1'b1, 4'b1111);
    check("wrap_count", 32'(bus.free_count), 4);
    expect_ids("wrap", 30, 31, 0, 1);

    // Flush to partitions 0 and 2 while frees and a bundle are present.
    cyc(1'b1, 4'b1111, 4'b1111, ids(30, 31, 0, 1), 1'b1, 4'b0101);
    check("flush_fire", 32'(bus.dispatch_fire), 0);
    for (int l = 0; l < 4; l++) check($sformatf("flush_v%0d", l), 32'(bus.free_entry[l].valid), 0);
    cyc(1'b1, 4'b1111);
    check("flush_count", 32'(bus.free_count), 16);
    expect_ids("part_a", 0, 1, 2, 3);
    cyc(1'b1, 4'b1111);
    expect_ids("part_b", 4, 5, 6, 7);
    cyc(1'b1, 4'b1111);
    expect_ids("part_c", 16, 17, 18, 19);
    cyc(1'b1, 4'b1111);
    expect_ids("part_d", 20, 21, 22, 23);

    // Build count to 10, then async reset mid-cycle.
    cyc(1'b0, 4'b0000, 4'b1111, ids(0, 1, 2, 3));
    check("drained_count", 32'(bus.free_count), 0);
    cyc(1'b0, 4'b0000, 4'b1111, ids(4, 5, 6, 7));
    cyc(1'b0, 4'b0000, 4'b0011, ids(16, 17, 0, 0));
    cyc(1'b0, 4'b0000);
    check("pre_reset_count", 32'(bus.free_count), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_count", 32'(bus.free_count), 32);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set(1'b1, 4'b1111);
    #3;
    expect_ids("post_reset", 0, 1, 2, 3);
    cyc(1'b0, 4'b0000);
    check("post_reset_count", 32'(bus.free_count), 28);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
